// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the load/store unit and memory.
// The master side issues requests; the slave side answers with ack and read data.
interface mem_lsu_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_lsu.sv
// Memory-access stage: byte/half/word loads and stores over a req/ack bus,
// with misalignment detection, bus timeout and a registered write-back result.
//
// state  | meaning
// S_IDLE | accepting instructions; NOP-class and misaligned ops retire in one cycle
// S_BUS  | bus request outstanding; waiting for ack or timeout
module mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] store_data_i,
    output logic        stall_req_o,
    mem_lsu_if.master   bus,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [7:0] TC     = 8'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  op_q;
    logic [4:0]  wd_q;
    logic        wreg_q;
    logic [31:0] addr_q;
    logic [3:0]  sel_q;
    logic [31:0] sdata_q;
    logic        we_q;
    logic        req_q;

    logic        is_load, is_store, is_half, is_word, misalign, accept_mem;
    logic [3:0]  sel_n;
    logic [31:0] sdata_n;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;

    always_comb begin
        is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LHU);
        is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
        is_half  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
        is_word  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
        misalign = (is_half && wdata_i[0]) || (is_word && (wdata_i[1:0] != 2'b00));
        sel_n    = 4'b0001 << wdata_i[1:0];
        sdata_n  = {4{store_data_i[7:0]}};
        if (is_half) begin
            sel_n   = wdata_i[1] ? 4'b1100 : 4'b0011;
            sdata_n = {2{store_data_i[15:0]}};
        end else if (is_word) begin
            sel_n   = 4'b1111;
            sdata_n = store_data_i;
        end
        accept_mem = (state == S_IDLE) && valid_i && (is_load || is_store) && !misalign;
    end

    // Stall releases in the completing cycle so upstream advances on that same edge.
    assign stall_req_o = accept_mem ||
                         ((state == S_BUS) && !bus.bus_ack_i && (cnt != TC));

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_v = bus.bus_rdata_i[7:0];
            2'd1:    byte_v = bus.bus_rdata_i[15:8];
            2'd2:    byte_v = bus.bus_rdata_i[23:16];
            default: byte_v = bus.bus_rdata_i[31:24];
        endcase
        half_v = addr_q[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
        case (op_q)
            OP_LB:   load_v = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_v = {24'd0, byte_v};
            OP_LH:   load_v = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_v = {16'd0, half_v};
            default: load_v = bus.bus_rdata_i;
        endcase
    end

    assign bus.bus_req_o   = req_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus.bus_sel_o   = sel_q;
    assign bus.bus_wdata_o = sdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            op_q       <= 4'd0;
            wd_q       <= 5'd0;
            wreg_q     <= 1'b0;
            addr_q     <= 32'd0;
            sel_q      <= 4'd0;
            sdata_q    <= 32'd0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            valid_o    <= 1'b0;
            wd_o       <= 5'd0;
            wreg_o     <= 1'b0;
            wdata_o    <= 32'd0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_mem) begin
                        op_q    <= mem_op_i;
                        wd_q    <= wd_i;
                        wreg_q  <= wreg_i;
                        addr_q  <= wdata_i;
                        sel_q   <= sel_n;
                        sdata_q <= sdata_n;
                        we_q    <= is_store;
                        req_q   <= 1'b1;
                        cnt     <= 8'd0;
                        state   <= S_BUS;
                    end else if (valid_i) begin
                        valid_o    <= 1'b1;
                        misalign_o <= misalign;
                        wd_o       <= wd_i;
                        wreg_o     <= wreg_i && !misalign;
                        wdata_o    <= wdata_i;
                    end
                end
                S_BUS: begin
                    if (bus.bus_ack_i) begin
                        req_q   <= 1'b0;
                        state   <= S_IDLE;
                        valid_o <= 1'b1;
                        wd_o    <= wd_q;
                        wreg_o  <= we_q ? 1'b0 : wreg_q;
                        wdata_o <= we_q ? 32'd0 : load_v;
                    end else if (cnt == TC) begin
                        req_q     <= 1'b0;
                        state     <= S_IDLE;
                        valid_o   <= 1'b1;
                        bus_err_o <= 1'b1;
                        wd_o      <= wd_q;
                        wreg_o    <= 1'b0;
                        wdata_o   <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: expected write-back entries are queued when an
// instruction is driven and popped when valid_o is expected.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [3:0]  mem_op_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [31:0] store_data_i = '0;
    logic        stall_req_o, valid_o, wreg_o, misalign_o, bus_err_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;

    mem_lsu_if bus_if ();

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .store_data_i(store_data_i), .stall_req_o(stall_req_o), .bus(bus_if),
        .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic mis, input logic err);
        exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.mis = mis; e.err = err;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] wdata, input logic [31:0] sdata);
        valid_i = v; mem_op_i = op; wd_i = wd; wreg_i = wreg;
        wdata_i = wdata; store_data_i = sdata;
        #1;
    endtask

    task automatic step(input logic exp_valid);
        exp_t e;
        @(posedge clk);
        #1;
        chk("valid_o", {31'd0, valid_o}, {31'd0, exp_valid});
        if (exp_valid) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL scoreboard_empty observed=valid expected=entry");
            end else begin
                e = sb.pop_front();
                chk("wd_o", {27'd0, wd_o}, {27'd0, e.wd});
                chk("wreg_o", {31'd0, wreg_o}, {31'd0, e.wreg});
                chk("wdata_o", wdata_o, e.wdata);
                chk("misalign_o", {31'd0, misalign_o}, {31'd0, e.mis});
                chk("bus_err_o", {31'd0, bus_err_o}, {31'd0, e.err});
            end
        end else begin
            chk("misalign_idle", {31'd0, misalign_o}, 32'd0);
            chk("bus_err_idle", {31'd0, bus_err_o}, 32'd0);
        end
    endtask

    task automatic ack(input logic a, input logic [31:0] rd);
        bus_if.bus_ack_i = a;
        bus_if.bus_rdata_i = rd;
        #1;
    endtask

    // Simple single-cycle-ack memory access: accept, one BUS cycle with ack.
    task automatic quick(input string tag, input logic [3:0] op, input logic [4:0] wd,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rd, input logic [3:0] esel,
                         input logic [31:0] ewdata, input logic ewreg, input logic [31:0] eres);
        drive(1'b1, op, wd, 1'b1, addr, sdata);
        chk({tag, "_stall_acc"}, {31'd0, stall_req_o}, 32'd1);
        push(wd, ewreg, eres, 1'b0, 1'b0);
        step(1'b0);
        chk({tag, "_req"}, {31'd0, bus_if.bus_req_o}, 32'd1);
        chk({tag, "_addr"}, bus_if.bus_addr_o, {addr[31:2], 2'b00});
        chk({tag, "_sel"}, {28'd0, bus_if.bus_sel_o}, {28'd0, esel});
        if (op >= 4'd6) chk({tag, "_bwdata"}, bus_if.bus_wdata_o, ewdata);
        ack(1'b1, rd);
        chk({tag, "_stall_ack"}, {31'd0, stall_req_o}, 32'd0);
        step(1'b1);
        ack(1'b0, 32'd0);
        drive(1'b0, 4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.bus_ack_i = 1'b0;
        bus_if.bus_rdata_i = '0;
        #12;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_req", {31'd0, bus_if.bus_req_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // NOP-class passthrough, back to back
        drive(1'b1, 4'd0, 5'd5, 1'b1, 32'h1234, 32'd0);
        chk("nop_stall", {31'd0, stall_req_o}, 32'd0);
        push(5'd5, 1'b1, 32'h1234, 1'b0, 1'b0);
        step(1'b1);
        drive(1'b1, 4'd9, 5'd7, 1'b0, 32'hAAAA_0001, 32'd0);
        chk("nop9_stall", {31'd0, stall_req_o}, 32'd0);
        push(5'd7, 1'b0, 32'hAAAA_0001, 1'b0, 1'b0);
        step(1'b1);
        drive(1'b1, 4'd15, 5'd31, 1'b1, 32'hFFFF_0002, 32'd0);
        push(5'd31, 1'b1, 32'hFFFF_0002, 1'b0, 1'b0);
        step(1'b1);
        drive(1'b0, 4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        step(1'b0);

        // LB at 0x103, ack two cycles after request
        drive(1'b1, 4'd1, 5'd3, 1'b1, 32'h103, 32'd0);
        chk("lb_stall0", {31'd0, stall_req_o}, 32'd1);
        chk("lb_noreq", {31'd0, bus_if.bus_req_o}, 32'd0);
        push(5'd3, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
        step(1'b0);
        chk("lb_req", {31'd0, bus_if.bus_req_o}, 32'd1);
        chk("lb_addr", bus_if.bus_addr_o, 32'h100);
        chk("lb_sel", {28'd0, bus_if.bus_sel_o}, 32'h8);
        chk("lb_we", {31'd0, bus_if.bus_we_o}, 32'd0);
        chk("lb_stall1", {31'd0, stall_req_o}, 32'd1);
        step(1'b0);
        chk("lb_stall2", {31'd0, stall_req_o}, 32'd1);
        chk("lb_addr_hold", bus_if.bus_addr_o, 32'h100);
        step(1'b0);
        ack(1'b1, 32'h80FF_0000);
        chk("lb_stall3", {31'd0, stall_req_o}, 32'd0);
        step(1'b1);
        ack(1'b0, 32'd0);
        drive(1'b0, 4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        chk("lb_req_drop", {31'd0, bus_if.bus_req_o}, 32'd0);

        // Stores and remaining load flavours
        quick("sh", 4'd7, 5'd9, 32'h202, 32'hDEAD_BEEF, 32'h1234_5678, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'd0);
        quick("sb", 4'd6, 5'd8, 32'h301, 32'h0000_00AB, 32'h0, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'd0);
        quick("sw", 4'd8, 5'd1, 32'h400, 32'h0BAD_F00D, 32'h0, 4'b1111, 32'h0BAD_F00D, 1'b0, 32'd0);
        quick("lh", 4'd2, 5'd10, 32'h12, 32'd0, 32'h8001_7FFF, 4'b1100, 32'd0, 1'b1, 32'hFFFF_8001);
        quick("lhu", 4'd5, 5'd11, 32'h10, 32'd0, 32'h1234_F00F, 4'b0011, 32'd0, 1'b1, 32'h0000_F00F);
        quick("lbu", 4'd4, 5'd12, 32'h1, 32'd0, 32'h0000_9A00, 4'b0010, 32'd0, 1'b1, 32'h0000_009A);
        quick("lb_pos", 4'd1, 5'd13, 32'h0, 32'd0, 32'hFFFF_FF7F, 4'b0001, 32'd0, 1'b1, 32'h0000_007F);

        // Misaligned accesses
        drive(1'b1, 4'd3, 5'd4, 1'b1, 32'h6, 32'd0);
        chk("mis_lw_stall", {31'd0, stall_req_o}, 32'd0);
        push(5'd4, 1'b0, 32'h6, 1'b1, 1'b0);
        step(1'b1);
        chk("mis_lw_noreq", {31'd0, bus_if.bus_req_o}, 32'd0);
        drive(1'b1, 4'd7, 5'd14, 1'b1, 32'h201, 32'h5555);
        push(5'd14, 1'b0, 32'h201, 1'b1, 1'b0);
        step(1'b1);
        chk("mis_sh_noreq", {31'd0, bus_if.bus_req_o}, 32'd0);
        drive(1'b0, 4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        step(1'b0);

        // Timeout with TIMEOUT=4, then NOP accepted immediately
        drive(1'b1, 4'd4, 5'd2, 1'b1, 32'h40, 32'd0);
        push(5'd2, 1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            chk("to_req", {31'd0, bus_if.bus_req_o}, 32'd1);
        end
        chk("to_stall_last", {31'd0, stall_req_o}, 32'd0);
        step(1'b1);
        chk("to_req_drop", {31'd0, bus_if.bus_req_o}, 32'd0);
        drive(1'b1, 4'd0, 5'd1, 1'b1, 32'h55, 32'd0);
        chk("to_nop_stall", {31'd0, stall_req_o}, 32'd0);
        push(5'd1, 1'b1, 32'h55, 1'b0, 1'b0);
        step(1'b1);

        // Ack coinciding with the terminal count wins
        drive(1'b1, 4'd3, 5'd15, 1'b1, 32'h80, 32'd0);
        push(5'd15, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0);
        ack(1'b1, 32'hCAFE_F00D);
        step(1'b1);
        ack(1'b0, 32'd0);

        // Ack while idle is ignored
        drive(1'b0, 4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        ack(1'b1, 32'hFFFF_FFFF);
        step(1'b0);
        ack(1'b0, 32'd0);
        step(1'b0);

        // Reset mid-transaction
        drive(1'b1, 4'd3, 5'd20, 1'b1, 32'h44, 32'd0);
        push(5'd20, 1'b1, 32'hDEAD_DEAD, 1'b0, 1'b0);
        step(1'b0);
        chk("mid_req_before", {31'd0, bus_if.bus_req_o}, 32'd1);
        #2;
        rst = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("mid_req", {31'd0, bus_if.bus_req_o}, 32'd0);
        chk("mid_stall", {31'd0, stall_req_o}, 32'd0);
        chk("mid_valid", {31'd0, valid_o}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b1, 4'd3, 5'd6, 1'b1, 32'h44, 32'd0);
        push(5'd6, 1'b1, 32'h1357_9BDF, 1'b0, 1'b0);
        step(1'b0);
        chk("post_addr", bus_if.bus_addr_o, 32'h44);
        ack(1'b1, 32'h1357_9BDF);
        step(1'b1);
        ack(1'b0, 32'd0);
        drive(1'b0, 4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute stage's destination address, write enable and result. The result is used as the effective address for loads and stores.
- Performs byte/half/word loads and stores over a req/ack data bus, with lane selection, sign/zero extension, misalignment detection and a bus timeout.
- Presents a registered write-back result and stalls upstream while a bus transaction is outstanding.

Parameters:
TIMEOUT, 255, max cycles to wait for bus_ack_i before aborting (1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low
valid_i  input  1  execute stage presents an instruction
mem_op_i  input  4  0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NOP
wd_i  input  5  destination register address
wreg_i  input  1  destination write enable
wdata_i  input  32  execute result; effective address when mem_op_i is a load/store
store_data_i  input  32  rs2 value for stores
stall_req_o  output  1  combinational; upstream holds its inputs while high
bus_req_o  output  1  bus request
bus_we_o  output  1  1 = store
bus_addr_o  output  32  word address {addr[31:2],2'b00}
bus_sel_o  output  4  byte lane enables
bus_wdata_o  output  32  store data, lane-replicated
bus_ack_i  input  1  bus completion, one-cycle pulse
bus_rdata_i  input  32  read data, valid with bus_ack_i
valid_o  output  1  write-back entry valid (registered)
wd_o  output  5  registered destination address
wreg_o  output  1  registered write enable
wdata_o  output  32  registered write-back data
misalign_o  output  1  registered; misaligned access flagged with valid_o
bus_err_o  output  1  registered; timeout flagged with valid_o

Behaviour:
- Reset (rst low, asynchronous): state IDLE, timeout counter 0. All outputs 0, including bus_req_o, which drops immediately even mid-transaction. A pending access is discarded.
- State machine: IDLE, BUS.
- IDLE, valid_i=0: valid_o=0 next cycle.
- IDLE, valid_i=1, NOP-class op: next cycle valid_o=1, wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i. Latency 1, no stall.
- Misalignment rule: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- IDLE, valid_i=1, misaligned: next cycle valid_o=1, misalign_o=1, wreg_o=0, wdata_o=wdata_i. No bus activity, no stall.
- IDLE, valid_i=1, aligned load/store:
  - stall_req_o=1 combinationally.
  - Latch op, wd, wreg, addr and store data.
  - Next cycle: enter BUS, counter cleared.
- Byte lanes (little-endian): SB/LB/LBU sel=4'b0001<<addr[1:0]; SH/LH/LHU sel=4'b0011 or 4'b1100 by addr[1]; SW/LW sel=4'b1111.
- Store data: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
- BUS state:
  - bus_req_o=1, stall_req_o=1.
  - bus_we_o, bus_addr_o, bus_sel_o and bus_wdata_o are driven from latched values, stable until ack.
  - Counter increments each cycle without ack.
- BUS, bus_ack_i=1: next cycle valid_o=1, return to IDLE, stall_req_o drops in the ack cycle.
  - Loads: wreg_o=latched wreg. wdata_o=selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW takes all 32 bits.
  - Stores: wreg_o=0, wdata_o=0.
- BUS, counter reaches TIMEOUT with no ack: next cycle valid_o=1, bus_err_o=1, wreg_o=0, bus_req_o drops, return to IDLE.
- Ack in the same cycle as the counter reaches TIMEOUT: ack wins, normal completion.
- bus_ack_i while in IDLE: ignored.
- valid_o, misalign_o and bus_err_o are single-cycle pulses per instruction.
- Whenever valid_o=0: misalign_o=0 and bus_err_o=0.
- Because stall_req_o is asserted in the accept cycle, no new instruction is accepted until the cycle after completion.
- Back-to-back instructions: a NOP-class instruction every cycle gives valid_o every cycle.

Test Plan:
- NOP-class passthrough: valid_i=1, op=0, wd=5, wreg=1, wdata=0x1234 -> next cycle valid_o=1, wd_o=5, wreg_o=1, wdata_o=0x1234, stall_req_o never high.
- Load byte with sign extension: LB at addr 0x103, bus acks 2 cycles after req with rdata=0x80FF_0000 -> bus_addr_o=0x100, sel=4'b1000, stall_req_o high 3 cycles, then wdata_o=0xFFFF_FF80, wreg_o=1.
- Store half: SH addr 0x202, store_data=0xDEAD_BEEF -> bus_we_o=1, sel=4'b1100, bus_wdata_o=0xBEEF_BEEF, addr=0x200; after ack valid_o=1, wreg_o=0.
- Misaligned word access: LW at addr 0x6 -> no bus_req_o, next cycle valid_o=1, misalign_o=1, wreg_o=0.
- Bus timeout: TIMEOUT=4, LBU with no ack -> bus_req_o high exactly 4 cycles, then valid_o=1, bus_err_o=1, wreg_o=0; a following NOP is accepted the next cycle.
- Reset mid-transaction: rst low mid-transaction (BUS state) between clock edges -> bus_req_o, stall_req_o and valid_o go 0 immediately; after release, a new LW with immediate ack completes normally with rdata passed through.
